// File: rtl/csr_pkg.sv
// CSR-side constants and types shared by the machine-mode interrupt logic.
// The mip/mie bit index of every source equals its mcause exception code.
package csr_pkg;

  localparam int CSR_MSI_BIT    = 3;
  localparam int CSR_MTI_BIT    = 7;
  localparam int CSR_MEI_BIT    = 11;
  localparam int CSR_LOCAL_BASE = 16;

  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  typedef logic [4:0] irq_code_t;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_BUSY = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_sync.sv
// Per-bit multi-flop synchroniser followed by a rising-edge detector.
// SYNC_STAGES = 0 passes the inputs straight through to the edge detector.
module irq_sync #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] level_d;

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign level = din;
    end else begin : g_sync
      logic [WIDTH-1:0] meta_p [SYNC_STAGES];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < SYNC_STAGES; s++) meta_p[s] <= '0;
        end else begin
          meta_p[0] <= din;
          for (int s = 1; s < SYNC_STAGES; s++) meta_p[s] <= meta_p[s-1];
        end
      end

      assign level = meta_p[SYNC_STAGES-1];
    end
  endgenerate

  // edge stage: one-cycle delayed copy of the synchronised level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_d <= '0;
    else     level_d <= level;
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: pending latch, priority select and a
// req/ack handshake towards the M-stage trap logic, blocked until mret.
module irq_ctrl
  import csr_pkg::*;
#(
  parameter int                   XLEN        = 32,
  parameter int                   NUM_LOCAL   = 16,
  parameter logic [NUM_LOCAL-1:0] LOCAL_EDGE  = '0,
  parameter int                   SYNC_STAGES = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          irq_software_i,
  input  logic                          irq_timer_i,
  input  logic                          irq_external_i,
  input  logic [NUM_LOCAL-1:0]          irq_local_i,
  input  logic [CSR_LOCAL_BASE+NUM_LOCAL-1:0] mie_i,
  input  logic                          mstatus_mie_i,
  input  logic [XLEN-1:0]               mtvec_i,
  input  logic                          irq_ack_i,
  input  logic                          mret_i,
  output logic                          irq_req_o,
  output logic [XLEN-1:0]               irq_cause_o,
  output logic [XLEN-1:0]               irq_target_o,
  output logic [CSR_LOCAL_BASE+NUM_LOCAL-1:0] mip_o,
  output logic                          busy_o
);

  localparam int NUM_SRC = 3 + NUM_LOCAL;
  localparam int MIP_W   = CSR_LOCAL_BASE + NUM_LOCAL;
  localparam logic [NUM_SRC-1:0] SRC_EDGE = {LOCAL_EDGE, 3'b000};
  localparam logic [MIP_W-1:0]   MIP_EDGE = {LOCAL_EDGE, 16'h0000};

  logic [NUM_SRC-1:0] src_raw, src_lvl, src_rise, src_set;
  logic [MIP_W-1:0]   mip_q, mip_d, mip_set, elig, code_oh, ack_clr;
  irq_state_t         state_q, state_d;
  irq_code_t          code_q, sel_code;
  logic               sel_vld, load, frozen_elig;
  logic [XLEN-1:0]    cause_q, target_q, sel_cause, sel_target, base;

  assign src_raw = {irq_local_i, irq_external_i, irq_timer_i, irq_software_i};

  irq_sync #(
    .WIDTH       (NUM_SRC),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk_i),
    .rst   (rst_i),
    .din   (src_raw),
    .level (src_lvl),
    .rise  (src_rise)
  );

  // Level sources follow the synchronised line, edge sources only see rises.
  assign src_set = (src_lvl & ~SRC_EDGE) | (src_rise & SRC_EDGE);

  always_comb begin
    mip_set = '0;
    mip_set[CSR_MSI_BIT] = src_set[0];
    mip_set[CSR_MTI_BIT] = src_set[1];
    mip_set[CSR_MEI_BIT] = src_set[2];
    for (int i = 0; i < NUM_LOCAL; i++) mip_set[CSR_LOCAL_BASE+i] = src_set[3+i];
  end

  assign code_oh     = MIP_W'(1) << code_q;
  assign ack_clr     = (state_q == IRQ_REQ && irq_ack_i) ? code_oh : '0;
  assign mip_d       = mip_set | (MIP_EDGE & mip_q & ~ack_clr);
  assign elig        = mstatus_mie_i ? (mip_q & mie_i) : '0;
  assign frozen_elig = |(elig & code_oh);

  // Fixed priority: MEI, MSI, MTI, then locals with the lowest index winning.
  always_comb begin
    sel_vld  = 1'b1;
    sel_code = '0;
    if (elig[CSR_MEI_BIT])      sel_code = irq_code_t'(CSR_MEI_BIT);
    else if (elig[CSR_MSI_BIT]) sel_code = irq_code_t'(CSR_MSI_BIT);
    else if (elig[CSR_MTI_BIT]) sel_code = irq_code_t'(CSR_MTI_BIT);
    else begin
      sel_vld = 1'b0;
      for (int i = NUM_LOCAL - 1; i >= 0; i--) begin
        if (elig[CSR_LOCAL_BASE+i]) begin
          sel_vld  = 1'b1;
          sel_code = irq_code_t'(CSR_LOCAL_BASE + i);
        end
      end
    end
  end

  always_comb begin
    sel_cause           = '0;
    sel_cause[XLEN-1]   = 1'b1;
    sel_cause[4:0]      = sel_code;
    base                = {mtvec_i[XLEN-1:2], 2'b00};
    sel_target          = (mtvec_i[1:0] == MTVEC_VECTORED) ?
                          base + (XLEN'(sel_code) << 2) : base;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IRQ_IDLE: begin
        if (sel_vld) begin
          state_d = IRQ_REQ;
          load    = 1'b1;
        end
      end
      IRQ_REQ: begin
        if (irq_ack_i)         state_d = IRQ_BUSY;
        else if (!frozen_elig) state_d = IRQ_IDLE;
      end
      IRQ_BUSY: begin
        if (mret_i) state_d = IRQ_IDLE;
      end
      default: state_d = IRQ_IDLE;
    endcase
  end

  // state stage: FSM, pending bits and the frozen request payload
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IRQ_IDLE;
      mip_q    <= '0;
      code_q   <= '0;
      cause_q  <= '0;
      target_q <= '0;
    end else begin
      state_q <= state_d;
      mip_q   <= mip_d;
      if (load) begin
        code_q   <= sel_code;
        cause_q  <= sel_cause;
        target_q <= sel_target;
      end
    end
  end

  assign irq_req_o    = (state_q == IRQ_REQ);
  assign busy_o       = (state_q == IRQ_BUSY);
  assign irq_cause_o  = cause_q;
  assign irq_target_o = target_q;
  assign mip_o        = mip_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Randomised and directed bench for irq_ctrl against a cycle-level reference
// model built from the pending/priority/handshake rules.
module tb_irq_ctrl;

  localparam int SYNC = 2;
  localparam logic [15:0] LEDGE = 16'h0004;
  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_BUSY = 2;

  logic        clk, rst;
  logic        irq_sw, irq_tim, irq_ext, mstatus_mie, ack, mret;
  logic [15:0] irq_loc;
  logic [31:0] mie, mtvec;
  logic        req, busy;
  logic [31:0] cause, target, mip;

  int total = 0;
  int bad   = 0;

  irq_ctrl #(
    .XLEN        (32),
    .NUM_LOCAL   (16),
    .LOCAL_EDGE  (LEDGE),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .irq_software_i (irq_sw),
    .irq_timer_i    (irq_tim),
    .irq_external_i (irq_ext),
    .irq_local_i    (irq_loc),
    .mie_i          (mie),
    .mstatus_mie_i  (mstatus_mie),
    .mtvec_i        (mtvec),
    .irq_ack_i      (ack),
    .mret_i         (mret),
    .irq_req_o      (req),
    .irq_cause_o    (cause),
    .irq_target_o   (target),
    .mip_o          (mip),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [18:0] hq[$];
  logic [31:0] m_mip, m_cause, m_target;
  int          m_mode, m_code;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] src2mip(input logic [18:0] s);
    logic [31:0] r;
    r        = '0;
    r[3]     = s[0];
    r[7]     = s[1];
    r[11]    = s[2];
    r[31:16] = s[18:3];
    return r;
  endfunction

  function automatic int prio_code(input int k);
    if (k == 0) return 11;
    if (k == 1) return 3;
    if (k == 2) return 7;
    return 13 + k;
  endfunction

  task automatic model_reset();
    hq = '{};
    for (int i = 0; i <= SYNC; i++) hq.push_back('0);
    m_mip = '0; m_mode = M_IDLE; m_code = 0; m_cause = '0; m_target = '0;
  endtask

  task automatic model_edge();
    logic [18:0] sv, sp;
    logic [31:0] lvl, rise, elig, clr, emask, base;
    bit found;
    sv    = hq[hq.size() - SYNC];
    sp    = hq[hq.size() - SYNC - 1];
    lvl   = src2mip(sv);
    rise  = src2mip(sv & ~sp);
    emask = {LEDGE, 16'h0000};
    elig  = mstatus_mie ? (m_mip & mie) : '0;
    clr   = '0;
    if (m_mode == M_REQ && ack) clr[m_code] = 1'b1;
    case (m_mode)
      M_IDLE: begin
        found = 0;
        for (int k = 0; k < 19; k++) begin
          if (!found && elig[prio_code(k)]) begin
            found    = 1;
            m_code   = prio_code(k);
            m_cause  = 32'h8000_0000 | 32'(m_code);
            base     = mtvec & 32'hFFFF_FFFC;
            m_target = (mtvec[1:0] == 2'b01) ? base + 32'(m_code * 4) : base;
            m_mode   = M_REQ;
          end
        end
      end
      M_REQ: begin
        if (ack)                 m_mode = M_BUSY;
        else if (!elig[m_code])  m_mode = M_IDLE;
      end
      default: if (mret) m_mode = M_IDLE;
    endcase
    m_mip = (lvl & ~emask) | ((rise | (m_mip & ~clr)) & emask);
    hq.push_back({irq_loc, irq_ext, irq_tim, irq_sw});
    if (hq.size() > 4) void'(hq.pop_front());
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    chk("req",    64'(req),    64'(m_mode == M_REQ));
    chk("busy",   64'(busy),   64'(m_mode == M_BUSY));
    chk("cause",  64'(cause),  64'(m_cause));
    chk("target", 64'(target), 64'(m_target));
    chk("mip",    64'(mip),    64'(m_mip));
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!req && n < 20) begin
      step();
      n++;
    end
    chk(tag, 64'(req), 64'd1);
  endtask

  task automatic take(); // ack the presented request
    ack = 1'b1; step(); ack = 1'b0;
  endtask

  task automatic do_mret();
    mret = 1'b1; step(); mret = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; irq_sw = 0; irq_tim = 0; irq_ext = 0; irq_loc = '0;
    mie = '0; mstatus_mie = 0; mtvec = '0; ack = 0; mret = 0;
    model_reset();
    repeat (3) step();
    chk("rst_req", 64'(req), 64'd0);
    chk("rst_mip", 64'(mip), 64'd0);
    #2 rst = 1'b0;

    // level MTI latency and re-request after mret
    mie = 32'h80; mstatus_mie = 1; irq_tim = 1;
    n = 0;
    while (!req && n < 10) begin step(); n++; end
    chk("mti_lat", 64'(n), 64'd4);
    chk("mti_cause", 64'(cause), 64'h8000_0007);
    take();
    chk("mti_busy", 64'(busy), 64'd1);
    chk("mti_req_low", 64'(req), 64'd0);
    do_mret();
    chk("mti_idle", 64'(req | busy), 64'd0);
    step();
    chk("mti_rereq", 64'(req), 64'd1);
    take(); irq_tim = 0; repeat (4) step(); do_mret(); step();

    // priority MEI > MSI > local 0
    mie = 32'hFFFF_FFFF; irq_ext = 1; irq_sw = 1; irq_loc = 16'h0001;
    wait_req("pri_req1");
    chk("pri_mei", 64'(cause), 64'h8000_000B);
    take(); irq_ext = 0; repeat (4) step(); do_mret();
    wait_req("pri_req2");
    chk("pri_msi", 64'(cause), 64'h8000_0003);
    take(); irq_sw = 0; repeat (4) step(); do_mret();
    wait_req("pri_req3");
    chk("pri_loc0", 64'(cause), 64'h8000_0010);
    take(); irq_loc = '0; repeat (4) step(); do_mret(); step();

    // edge-sensitive local 2
    irq_loc = 16'h0004; step(); irq_loc = '0;
    wait_req("edge_req");
    chk("edge_pend", 64'(mip[18]), 64'd1);
    repeat (2) step();
    chk("edge_hold", 64'(mip[18]), 64'd1);
    take();
    chk("edge_clr", 64'(mip[18]), 64'd0);
    do_mret();
    irq_loc = 16'h0004; step(); irq_loc = '0;
    wait_req("edge_req2");
    irq_loc = 16'h0004; step(); irq_loc = '0; step();
    take();
    chk("edge_set_wins", 64'(mip[18]), 64'd1);
    chk("edge_busy", 64'(busy), 64'd1);
    do_mret();
    wait_req("edge_again");
    take(); do_mret(); step();

    // handler target computation
    mtvec = 32'h0000_1001; irq_loc = 16'h0020;
    wait_req("vec_req");
    chk("vec_cause", 64'(cause), 64'h8000_0015);
    chk("vec_target", 64'(target), 64'h0000_1054);
    take(); mtvec = 32'h0000_1000; do_mret();
    wait_req("dir_req");
    chk("dir_target", 64'(target), 64'h0000_1000);
    take(); mtvec = 32'hFFFF_FFC1; irq_loc = 16'h0001; repeat (4) step(); do_mret();
    wait_req("wrap_req");
    chk("wrap_cause", 64'(cause), 64'h8000_0010);
    chk("wrap_target", 64'(target), 64'h0000_0000);
    take(); irq_loc = '0; repeat (4) step(); do_mret(); mtvec = '0; step();

    // withdrawal vs. ack
    irq_tim = 1;
    wait_req("wd_req1");
    mstatus_mie = 0; step();
    chk("wd_withdraw", 64'(req), 64'd0);
    chk("wd_idle", 64'(busy), 64'd0);
    mstatus_mie = 1;
    wait_req("wd_req2");
    mstatus_mie = 0; take();
    chk("wd_ack_wins", 64'(busy), 64'd1);
    mstatus_mie = 1; do_mret();

    // asynchronous reset while busy with an edge pending
    wait_req("ar_req");
    take();
    irq_loc = 16'h0004; step(); irq_loc = '0; repeat (3) step();
    chk("ar_pend", 64'(mip[18]), 64'd1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("ar_req0", 64'(req), 64'd0);
    chk("ar_busy0", 64'(busy), 64'd0);
    chk("ar_cause0", 64'(cause), 64'd0);
    chk("ar_target0", 64'(target), 64'd0);
    chk("ar_mip0", 64'(mip), 64'd0);
    irq_tim = 0; step(); step();
    rst = 1'b0;

    // randomised traffic against the model
    mie = 32'hFFFF_FFFF;
    repeat (3000) begin
      if ($urandom_range(9) == 0) irq_sw  = ~irq_sw;
      if ($urandom_range(9) == 0) irq_tim = ~irq_tim;
      if ($urandom_range(9) == 0) irq_ext = ~irq_ext;
      if ($urandom_range(5) == 0) irq_loc = irq_loc ^ (16'h1 << $urandom_range(15));
      if ($urandom_range(49) == 0) mie = $urandom | $urandom;
      if ($urandom_range(49) == 0) mtvec = $urandom;
      mstatus_mie = ($urandom_range(19) != 0);
      ack  = 1'($urandom_range(1));
      mret = ($urandom_range(5) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Parametrised machine-mode interrupt controller for the core.
- Handles the three standard sources (MSI/MTI/MEI) plus NUM_LOCAL platform local interrupts (mcause codes 16+i).
- Synchronises inputs and latches edge-sensitive sources into pending state (mip).
- Priority-selects one eligible interrupt and presents it to the trap logic in the M stage over a req/ack handshake. Supplies mcause and the direct/vectored handler PC.
- Blocks further requests until mret.

Parameters:
XLEN, 32, datapath width of mcause/mtvec/target PC
NUM_LOCAL, 16, number of local interrupt lines (0..XLEN-16)
LOCAL_EDGE, '0 (NUM_LOCAL bits), bit i=1: local i is rising-edge sensitive, else level
SYNC_STAGES, 2, synchroniser flops per input (0 = inputs already synchronous, bypass)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
irq_software_i  in  1  machine software interrupt (level)
irq_timer_i  in  1  machine timer interrupt (level)
irq_external_i  in  1  machine external interrupt (level)
irq_local_i  in  NUM_LOCAL  local interrupt lines
mie_i  in  16+NUM_LOCAL  mie CSR enable bits (bit positions as mip)
mstatus_mie_i  in  1  global machine interrupt enable
mtvec_i  in  XLEN  mtvec CSR value
irq_ack_i  in  1  trap logic has taken the presented interrupt this cycle
mret_i  in  1  mret retiring in M stage
irq_req_o  out  1  interrupt request to trap logic
irq_cause_o  out  XLEN  mcause value for presented interrupt (bit XLEN-1 = 1)
irq_target_o  out  XLEN  handler PC for presented interrupt
mip_o  out  16+NUM_LOCAL  pending bits for mip CSR readback
busy_o  out  1  handler active (between ack and mret)

Behaviour:
- Reset: all synchroniser/edge flops 0, mip_o=0, irq_req_o=0, irq_cause_o=0, irq_target_o=0, busy_o=0, FSM=IDLE. Reset mid-handshake or mid-handler returns to IDLE immediately; latched edge pendings are lost.
- Synchronisation: each input passes SYNC_STAGES flops. Edge detect compares the synchronised value with a 1-cycle-delayed copy.
- mip bit mapping: bit 3 = MSI, bit 7 = MTI, bit 11 = MEI, bit 16+i = local i. Other bits are hard 0.
- Level sources: mip bit = registered synchronised input.
- Edge sources: mip bit set on a synchronised rising edge; cleared the cycle after irq_ack_i when the presented code is that source. Set and clear in the same cycle: set wins (bit stays 1).
- Eligible = mip & mie_i, gated by mstatus_mie_i.
- Priority, highest first: MEI, MSI, MTI, then local 0..NUM_LOCAL-1 (lowest index wins).
- FSM:
  - IDLE: if any eligible, register the selected code, cause, target; go to REQ. irq_req_o=1 from the next edge.
  - REQ: code/cause/target frozen.
    - irq_ack_i=1: go to BUSY, clear edge pending if applicable.
    - Else, if the frozen source is no longer eligible (level dropped, mie/mstatus cleared): withdraw, go to IDLE, irq_req_o=0 next cycle.
    - Ack and loss of eligibility in the same cycle: ack wins.
    - A higher-priority source arriving in REQ does not pre-empt.
  - BUSY: irq_req_o=0, busy_o=1, no new requests. mret_i → IDLE. mret_i in IDLE/REQ is ignored.
- irq_ack_i while irq_req_o=0 is ignored.
- Latency: with inputs stable, level raise → irq_req_o high on the (SYNC_STAGES+2)th rising edge.
- irq_cause_o = {1'b1, (XLEN-6)'b0, code[4:0]}.
- Target PC:
  - base = {mtvec_i[XLEN-1:2], 2'b00}.
  - mtvec_i[1:0]==01 (vectored): base + (code << 2), XLEN wrap-around.
  - Otherwise (direct, reserved 10/11): base.
  - mtvec_i is sampled when entering REQ.

Decomposition:
- csr_pkg gains: CSR_LOCAL_BASE=16, an irq_code_t (5-bit) typedef, and an MTVEC_VECTORED mode constant. Existing CSR_MSI_BIT/CSR_MTI_BIT/CSR_MEI_BIT are reused.
- Sub-module irq_sync: per-bit SYNC_STAGES synchroniser plus rising-edge detector. Instantiated once, with width 3+NUM_LOCAL.

Test Plan:
- Level MTI, mie[7]=1, mstatus_mie=1, SYNC_STAGES=2 → irq_req_o high 4 edges after assert, cause=0x80000007. Ack → busy_o=1, req low. mret → IDLE; MTI still high → req again after 1 edge.
- MEI+MSI+local 0 raised together → cause 0x8000000B. After ack+mret with MEI dropped → 0x80000003, then 0x80000010.
- LOCAL_EDGE[2]=1, 1-cycle pulse on local 2 → mip_o[18] stays 1 until ack, then 0. New pulse coinciding with ack → mip_o[18] stays 1.
- mtvec=0x0000_1001, local 5 (code 21) → irq_target_o=0x0000_1054. mtvec=0x0000_1000 → 0x0000_1000. mtvec=0xFFFF_FFC1, code 16 → 0x0000_0000 (wrap).
- In REQ, clear mstatus_mie without ack → irq_req_o low next cycle, FSM IDLE. Repeat with ack in the same cycle → BUSY.
- Assert rst_i asynchronously while BUSY with edge pending set → all outputs 0 immediately, mip_o=0.
